// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, default frame marker and checksum helper
// for the program_loader boot loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CHK_WIDTH         = 8;

  // Modulo-256 running checksum step.
  function automatic logic [CHK_WIDTH-1:0] chk_add(
    input logic [CHK_WIDTH-1:0] sum,
    input logic [CHK_WIDTH-1:0] data
  );
    return sum + data;
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// loader_timeout_counter: inactivity counter for the boot loader; only
// instantiated when LOADER_TIMEOUT_EN is defined.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Idle-cycle counter: cleared by any transfer or outside a frame, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear || !active) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r != LIMIT) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = active && (count_r == LIMIT);

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a SYNC/LEN/payload/CHK framed image and writes it to
// program memory from address 0, holding the CPU in reset until a good frame ends.
// Define LOADER_TIMEOUT_EN to abandon frames after TIMEOUT_CYCLES idle cycles.
module program_loader
  import loader_pkg::*;
#(
  parameter int         ADD_WIDTH      = 7,
  parameter int         DATA_WIDTH     = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  pm_wr_en,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] pm_wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int REM_W   = ADD_WIDTH + 1;
  localparam int MAX_LEN = 1 << ADD_WIDTH;

  loader_state_e state_r, state_s;

  logic                  in_ready_r;
  logic [ADD_WIDTH-1:0]  addr_r, addr_s;
  logic [REM_W-1:0]      rem_r, rem_s;
  logic [CHK_WIDTH-1:0]  sum_r, sum_s;
  logic                  wr_en_r, wr_en_s;
  logic [ADD_WIDTH-1:0]  wr_addr_r, wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_r, wr_data_s;
  logic                  hold_r, hold_s;
  logic                  done_r, done_s;
  logic                  err_r, err_s;

  logic xfer_s;
  logic timeout_s;
  logic len_too_big_s;
  logic [CHK_WIDTH-1:0] chk_sum_s;

  assign xfer_s        = in_valid && in_ready_r;
  assign len_too_big_s = (ADD_WIDTH < 8) && (int'(in_data) > MAX_LEN);
  assign chk_sum_s     = chk_add(sum_r, in_data);

`ifdef LOADER_TIMEOUT_EN
  loader_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (xfer_s),
    .active  (state_r != IDLE),
    .expired (timeout_s)
  );
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES > 0);
  assign timeout_s            = 1'b0;
`endif

  // Frame parser: next state, write request and sticky status flags.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    rem_s     = rem_r;
    sum_s     = sum_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    hold_s    = hold_r;
    done_s    = done_r;
    err_s     = err_r;
    case (state_r)
      IDLE: begin
        if (xfer_s && (in_data == SYNC_BYTE)) begin
          state_s = LEN;
          hold_s  = 1'b1;
          done_s  = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LEN: begin
        if (xfer_s) begin
          if (len_too_big_s) begin
            err_s   = 1'b1;
            state_s = IDLE;
          end else begin
            // A zero length byte stands for a full-memory image.
            rem_s   = (in_data == 8'd0) ? REM_W'(MAX_LEN) : REM_W'(in_data);
            addr_s  = {ADD_WIDTH{1'b0}};
            sum_s   = {CHK_WIDTH{1'b0}};
            state_s = DATA;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          hold_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = LEN;
        end
      end
      DATA: begin
        if (xfer_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = addr_r;
          wr_data_s = DATA_WIDTH'(in_data);
          addr_s    = addr_r + ADD_WIDTH'(1);
          sum_s     = chk_sum_s;
          rem_s     = rem_r - REM_W'(1);
          if (rem_r == REM_W'(1)) begin
            state_s = CHK;
          end else begin
            state_s = DATA;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          hold_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = DATA;
        end
      end
      CHK: begin
        if (xfer_s) begin
          if (chk_sum_s == {CHK_WIDTH{1'b0}}) begin
            done_s = 1'b1;
            hold_s = 1'b0;
          end else begin
            err_s  = 1'b1;
            hold_s = 1'b1;
          end
          state_s = IDLE;
        end else if (timeout_s) begin
          err_s   = 1'b1;
          hold_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = CHK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      addr_r     <= {ADD_WIDTH{1'b0}};
      rem_r      <= {REM_W{1'b0}};
      sum_r      <= {CHK_WIDTH{1'b0}};
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADD_WIDTH{1'b0}};
      wr_data_r  <= {DATA_WIDTH{1'b0}};
      hold_r     <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= 1'b1;
      addr_r     <= addr_s;
      rem_r      <= rem_s;
      sum_r      <= sum_s;
      wr_en_r    <= wr_en_s;
      wr_addr_r  <= wr_addr_s;
      wr_data_r  <= wr_data_s;
      hold_r     <= hold_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign pm_wr_en   = wr_en_r;
  assign pm_addr    = wr_addr_r;
  assign pm_wr_data = wr_data_r;
  assign cpu_hold   = hold_r;
  assign load_done  = done_r;
  assign load_error = err_r;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that writes the CPU's program memory through its write port: write-enable, 7-bit address, 8-bit data.
- Receives a framed image (SYNC, LEN, payload, CHK) on a valid/ready byte interface. Writes payload bytes to sequential addresses starting at 0.
- Holds the CPU in reset until a frame with a correct checksum has completed.
- Sits between the off-chip byte source and the pipelined CPU's program-memory load port.

Parameters:
- ADD_WIDTH, 7, program-memory address width; maximum image size is 2^ADD_WIDTH bytes.
- DATA_WIDTH, 8, program-memory write data width; must be 8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, inactivity limit, used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-source data valid.
- in_data  in  8  byte-source data.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready at a rising clk edge.
- pm_wr_en  out  1  program-memory write enable.
- pm_addr  out  ADD_WIDTH  program-memory write address.
- pm_wr_data  out  DATA_WIDTH  program-memory write data.
- cpu_hold  out  1  active-high; keeps the CPU in reset while asserted.
- load_done  out  1  sticky; last frame completed with a good checksum.
- load_error  out  1  sticky; last frame failed.

Behaviour:
- Reset (rst=0, asynchronous) drives these values:
  - state=IDLE, in_ready=0, pm_wr_en=0, pm_addr=0, pm_wr_data=0.
  - cpu_hold=1, load_done=0, load_error=0.
  - Byte count and checksum cleared.
  - in_ready goes to 1 on the first clock after reset deasserts.
- in_ready is 1 in every state when not in reset. No backpressure is applied; every transfer is consumed in the cycle it occurs.
- IDLE:
  - A transferred byte equal to SYNC_BYTE moves the FSM to LEN. It also sets cpu_hold=1 and clears load_done and load_error.
  - Any other byte is discarded and flags are unchanged.
- LEN:
  - The transferred byte L is the image length; L=0 encodes 2^ADD_WIDTH bytes.
  - If ADD_WIDTH<8 and L>2^ADD_WIDTH, set load_error=1 and return to IDLE.
  - Otherwise latch remaining=L, clear addr and sum, and go to DATA.
- DATA:
  - Each transferred byte produces a registered write: on the following cycle pm_wr_en=1 for exactly 1 cycle, pm_addr=current addr, pm_wr_data=byte.
  - Then addr increments, sum = (sum + byte) mod 256, and remaining decrements.
  - When the last byte transfers, go to CHK.
  - Back-to-back bytes give back-to-back write pulses.
  - Writes never wrap, because addr stays at or below 2^ADD_WIDTH-1.
- CHK:
  - Compute (sum + byte) mod 256 with the transferred byte.
  - If the result is 0: load_done=1, and cpu_hold falls on the next cycle.
  - Otherwise load_error=1 and cpu_hold stays 1.
  - Either way return to IDLE.
- Reload: a SYNC received while IDLE after a completed frame restarts the load and reasserts cpu_hold immediately.
- SYNC_BYTE values arriving inside LEN, DATA or CHK are treated as ordinary data.
- Reset mid-frame abandons the frame. Memory already written keeps its contents, and cpu_hold=1.
- Gaps with in_valid=0 of any length are allowed when LOADER_TIMEOUT_EN is undefined.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined: a counter clears on every transfer and increments each cycle while in LEN, DATA or CHK. When it reaches TIMEOUT_CYCLES-1 the FSM sets load_error=1, keeps cpu_hold=1, and returns to IDLE.
- Undefined: no counter, and no timeout path.

Decomposition:
- Shared package (loader_pkg) holds:
  - state encoding: IDLE=2'd0, LEN=2'd1, DATA=2'd2, CHK=2'd3;
  - default SYNC_BYTE;
  - checksum width constant.
- One natural sub-module, loader_timeout_counter, instantiated only under LOADER_TIMEOUT_EN.
- The FSM and write register stay in program_loader.

Test Plan:
- Stream A5,03,13,05,00,E8:
  - pm writes (0,13),(1,05),(2,00), one cycle after each accept;
  - load_done=1, load_error=0, cpu_hold falls after the CHK byte.
- Same frame with CHK=E9 -> three writes occur; load_error=1, load_done=0, cpu_hold stays 1.
- Bytes 00,FF,3C before A5,01,7F,81 -> leading bytes ignored with no writes; single write (0,7F); load_done=1.
- A5,00 followed by 128 bytes of 01 and then CHK 80 -> 128 writes covering addresses 0..127 with no wrap; load_done=1.
- Assert rst after the second payload byte, then send a full frame -> outputs at reset values; new frame writes from address 0 and completes.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: A5,04,11 then idle for 20 cycles -> load_error=1, FSM returns to IDLE, a following A5 is accepted as sync.
